// File: rtl/hazard_stall_controller_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX/MEM hazard inputs, MDU and data-memory
// handshakes in; stall, bubble, flush and freeze controls out.
interface hazard_stall_controller_if;
    logic [4:0]  rs1_addr_id;
    logic [4:0]  rs2_addr_id;
    logic        rs1_valid_id;
    logic        rs2_valid_id;
    logic [4:0]  rd_addr_ex;
    logic        rd_valid_ex;
    logic        is_load_ex;
    logic [4:0]  rd_addr_mem;
    logic        rd_valid_mem;
    logic        is_load_mem;
    logic        branch_taken_ex;
    logic        mdu_req_ex;
    logic        mdu_done;
    logic        dmem_req_mem;
    logic        dmem_ready;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_stall;
    logic        ex_mem_bubble;
    logic        freeze;
    logic        mdu_start;
    logic        mdu_timeout;
    logic [31:0] stall_count;
    logic [1:0]  state_o;

    modport master (
        output rs1_addr_id, rs2_addr_id, rs1_valid_id, rs2_valid_id,
               rd_addr_ex, rd_valid_ex, is_load_ex,
               rd_addr_mem, rd_valid_mem, is_load_mem,
               branch_taken_ex, mdu_req_ex, mdu_done, dmem_req_mem, dmem_ready,
        input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_stall, ex_mem_bubble, freeze, mdu_start, mdu_timeout,
               stall_count, state_o
    );

    modport slave (
        input  rs1_addr_id, rs2_addr_id, rs1_valid_id, rs2_valid_id,
               rd_addr_ex, rd_valid_ex, is_load_ex,
               rd_addr_mem, rd_valid_mem, is_load_mem,
               branch_taken_ex, mdu_req_ex, mdu_done, dmem_req_mem, dmem_ready,
        output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_stall, ex_mem_bubble, freeze, mdu_start, mdu_timeout,
               stall_count, state_o
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline: covers load-use, multi-cycle
// MDU and data-memory wait hazards that WB-only forwarding cannot resolve.
module hazard_stall_controller #(
    parameter int LOAD_USE_PENALTY = 2,
    parameter int MDU_TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hazard_stall_controller_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_LOAD_WAIT = 2'd1,
        S_MDU_BUSY  = 2'd2
    } state_t;

    localparam int TW = $clog2(MDU_TIMEOUT + 1);

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic [TW-1:0] r_timer;
    logic          r_timeout;
    logic [31:0]   r_stall_count;

    logic w_use_ex, w_use_mem, w_load_use, w_freeze, w_timer_last;
    logic w_pc_stall, w_if_id_stall, w_id_ex_bubble, w_if_id_flush, w_id_ex_flush;
    logic w_ex_stall, w_ex_mem_bubble, w_mdu_start;

    assign w_use_ex = bus.rd_valid_ex && (bus.rd_addr_ex != 5'd0) &&
                      ((bus.rs1_valid_id && bus.rs1_addr_id == bus.rd_addr_ex) ||
                       (bus.rs2_valid_id && bus.rs2_addr_id == bus.rd_addr_ex));
    assign w_use_mem = bus.rd_valid_mem && (bus.rd_addr_mem != 5'd0) &&
                       ((bus.rs1_valid_id && bus.rs1_addr_id == bus.rd_addr_mem) ||
                        (bus.rs2_valid_id && bus.rs2_addr_id == bus.rd_addr_mem));
    assign w_load_use   = (bus.is_load_ex && w_use_ex) || (bus.is_load_mem && w_use_mem);
    assign w_freeze     = bus.dmem_req_mem && !bus.dmem_ready;
    assign w_timer_last = (r_timer == TW'(MDU_TIMEOUT - 1));

    // Controls are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_ex_stall      = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_mdu_start     = 1'b0;
        if (!rst_n) begin
            w_pc_stall = 1'b0;
        end else if (w_freeze) begin
            w_pc_stall = 1'b1;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (bus.branch_taken_ex) begin
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end else if (bus.mdu_req_ex) begin
                        w_mdu_start     = 1'b1;
                        w_pc_stall      = 1'b1;
                        w_if_id_stall   = 1'b1;
                        w_ex_stall      = 1'b1;
                        w_ex_mem_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_stall     = 1'b1;
                        w_if_id_stall  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end
                end
                S_LOAD_WAIT: begin
                    w_pc_stall     = 1'b1;
                    w_if_id_stall  = 1'b1;
                    w_id_ex_bubble = 1'b1;
                end
                S_MDU_BUSY: begin
                    if (!bus.mdu_done && !w_timer_last) begin
                        w_pc_stall      = 1'b1;
                        w_if_id_stall   = 1'b1;
                        w_ex_stall      = 1'b1;
                        w_ex_mem_bubble = 1'b1;
                    end
                end
                default: w_pc_stall = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the asynchronous reset clears every register, so no pending stall survives it.
            r_state       <= S_RUN;
            r_cnt         <= 2'd0;
            r_timer       <= '0;
            r_timeout     <= 1'b0;
            r_stall_count <= 32'd0;
        end else begin
            if (w_pc_stall) r_stall_count <= r_stall_count + 32'd1;
            if (!w_freeze) begin
                unique case (r_state)
                    S_RUN: begin
                        if (!bus.branch_taken_ex) begin
                            if (bus.mdu_req_ex) begin
                                r_state <= S_MDU_BUSY;
                                r_timer <= '0;
                            end else if (bus.is_load_ex && w_use_ex && LOAD_USE_PENALTY > 1) begin
                                r_state <= S_LOAD_WAIT;
                                r_cnt   <= 2'(LOAD_USE_PENALTY - 1);
                            end
                        end
                    end
                    S_LOAD_WAIT: begin
                        r_cnt <= r_cnt - 2'd1;
                        if (r_cnt <= 2'd1) r_state <= S_RUN;
                    end
                    S_MDU_BUSY: begin
                        if (bus.mdu_done) begin
                            r_state <= S_RUN;
                        end else if (w_timer_last) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_RUN;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    default: r_state <= S_RUN;
                endcase
            end
        end
    end

    assign bus.pc_stall      = w_pc_stall;
    assign bus.if_id_stall   = w_if_id_stall;
    assign bus.id_ex_bubble  = w_id_ex_bubble;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_ex_flush   = w_id_ex_flush;
    assign bus.ex_stall      = w_ex_stall;
    assign bus.ex_mem_bubble = w_ex_mem_bubble;
    assign bus.freeze        = rst_n && w_freeze;
    assign bus.mdu_start     = w_mdu_start;
    assign bus.mdu_timeout   = r_timeout;
    assign bus.stall_count   = r_stall_count;
    assign bus.state_o       = r_state;
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences the 5-stage pipeline around the hazards the EX-stage forwarding logic cannot resolve. That logic never forwards a load result from MEM, forwards only from WB, and has no notion of multi-cycle ops, branches or memory wait.
- Generates PC/IF-ID stall, ID-EX/EX-MEM bubble, branch flush and global freeze controls.
- Runs the start/done handshake with the multi-cycle mul/div unit (MDU).
- Sits beside the forwarding unit; drives the pipeline register enables/clears.

Parameters:
- LOAD_USE_PENALTY, 2, stall cycles for an ID consumer of a load in EX. Legal 1..3; 2 matches WB-only load forwarding.
- MDU_TIMEOUT, 64, maximum MDU_BUSY cycles before abort.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- rs1_addr_id  in  5  ID rs1
- rs2_addr_id  in  5  ID rs2
- rs1_valid_id  in  1  ID reads rs1
- rs2_valid_id  in  1  ID reads rs2
- rd_addr_ex  in  5  EX destination
- rd_valid_ex  in  1  EX writes rd
- is_load_ex  in  1  EX holds a load
- rd_addr_mem  in  5  MEM destination
- rd_valid_mem  in  1  MEM writes rd
- is_load_mem  in  1  MEM holds a load
- branch_taken_ex  in  1  EX redirects PC
- mdu_req_ex  in  1  EX holds MUL/DIV
- mdu_done  in  1  MDU result valid (1-cycle pulse)
- dmem_req_mem  in  1  MEM accessing data memory
- dmem_ready  in  1  data memory completes this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- if_id_flush  out  1  clear IF/ID
- id_ex_flush  out  1  clear ID/EX
- ex_stall  out  1  hold ID/EX (EX instruction stays)
- ex_mem_bubble  out  1  load NOP into EX/MEM
- freeze  out  1  hold every pipeline register
- mdu_start  out  1  one-cycle MDU launch pulse
- mdu_timeout  out  1  sticky error flag
- stall_count  out  32  cycles with pc_stall=1
- state_o  out  2  0 RUN, 1 LOAD_WAIT, 2 MDU_BUSY

Behaviour:
- State, counters, mdu_timeout and stall_count are registered. All other outputs are combinational from state and inputs.
- While rst_n=0: all outputs 0, state RUN, counters 0. Reset asserted mid-sequence aborts immediately; no pending stall survives reset.
- Hazard terms: use_ex = rd_valid_ex && rd_addr_ex!=0 && ((rs1_valid_id && rs1_addr_id==rd_addr_ex) || (rs2_valid_id && rs2_addr_id==rd_addr_ex)). use_mem is the same test against rd_addr_mem / rd_valid_mem.
- Global freeze: freeze = dmem_req_mem && !dmem_ready, in any state.
  - While freeze=1, no state change, counters hold, stall_count still increments.
  - All other outputs are forced to 0 except pc_stall=1.
  - mdu_start is deferred until freeze drops.
- RUN, priority high to low:
  1. branch_taken_ex: if_id_flush=1 and id_ex_flush=1. The load-use check is suppressed because the ID instruction is squashed.
  2. mdu_req_ex: mdu_start=1, pc_stall=if_id_stall=ex_stall=ex_mem_bubble=1. Next state MDU_BUSY, timer=0.
  3. is_load_ex && use_ex: pc_stall=if_id_stall=id_ex_bubble=1. If LOAD_USE_PENALTY>1, go to LOAD_WAIT with cnt=LOAD_USE_PENALTY-1; otherwise stay RUN.
  4. is_load_mem && use_mem: pc_stall=if_id_stall=id_ex_bubble=1 for one cycle, stay RUN.
- LOAD_WAIT:
  - pc_stall=if_id_stall=id_ex_bubble=1.
  - cnt decrements each unfrozen cycle; cnt reaching 1 in this cycle returns to RUN next cycle.
  - branch_taken_ex is ignored here (EX holds a bubble).
  - Total stall for PENALTY=2: 2 cycles. The consumer enters EX when the load is in WB.
- MDU_BUSY:
  - pc_stall=if_id_stall=ex_stall=ex_mem_bubble=1 until mdu_done.
  - In the mdu_done cycle all stalls deassert and the next state is RUN; the EX instruction advances with the result.
  - The timer increments each unfrozen cycle. At timer==MDU_TIMEOUT-1 without done: set mdu_timeout (sticky until reset), release stalls, return to RUN.
  - mdu_done while in RUN is ignored.
  - branch_taken_ex in MDU_BUSY is ignored.
- stall_count increments on every cycle with pc_stall=1 and wraps at 2^32.
- A freeze coinciding with mdu_done: done is not consumed and the state stays MDU_BUSY. The MDU must hold done until freeze clears, which is an integration requirement.

Test Plan:
- LW x5 in EX, ID ADD x6,x5,x1 (rs1_valid): pc_stall and id_ex_bubble high exactly 2 cycles, state 0→1→0, stall_count=2.
- LW x0 in EX, ID reads x0: no stall; then rd_addr_ex=5, rs2_valid_id=0, rs2_addr_id=5: no stall.
- branch_taken_ex together with a load-use hazard: if_id_flush=id_ex_flush=1 for one cycle, no stall, state stays RUN.
- mdu_req_ex, mdu_done after 10 cycles: mdu_start pulses once in the first cycle; ex_stall high 10 cycles, low in the done cycle; state 2→0.
- mdu_req_ex with no done, MDU_TIMEOUT=64: stalls release after 64 cycles, mdu_timeout=1 and stays 1; rst_n low clears it.
- dmem_ready=0 for 3 cycles during LOAD_WAIT: freeze=1 for 3 cycles, cnt held, LOAD_WAIT resumes and completes. Async rst_n pulse mid-MDU_BUSY: outputs 0 immediately, state RUN.
